// File: rtl/adc_uart_formatter_pkg.sv
// Shared constants for the ADC-to-UART ASCII formatter: ASCII codes, FSM states,
// field geometry and the ADC bus slicing macro.
`ifndef ADC_SLICE
`define ADC_SLICE(bus, k, w) bus[(k)*(w) +: (w)]
`endif

package adc_uart_formatter_pkg;

    localparam logic [7:0] ASCII_C    = 8'h43;
    localparam logic [7:0] ASCII_EQ   = 8'h3D;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_STAR = 8'h2A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;

    localparam int BYTES_PER_CH = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CONVERT,
        S_EMIT,
        S_TAIL
    } state_t;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_0 + {4'h0, d};
    endfunction

    // 'A' - 10 = 0x37
    function automatic logic [7:0] ascii_hex(input logic [3:0] d);
        return (d < 4'd10) ? (ASCII_0 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

endpackage

// File: rtl/adc_uart_formatter_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, done pulses
// ADC_W+1 clocks after start and bcd then holds until the next start.
module bin2bcd_seq #(
    parameter int ADC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADC_W-1:0] bin,
    output logic [15:0]      bcd,
    output logic             done
);

    localparam int CNT_W = $clog2(ADC_W + 1);

    logic [ADC_W-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic [15:0]      adj;

    function automatic logic [15:0] dabble(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign adj = dabble(bcd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr   <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            bcd  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr  <= bin;
                bcd <= '0;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                bcd <= {adj[14:0], sr[ADC_W-1]};
                sr  <= sr << 1;
                cnt <= cnt + 1'b1;
                if (cnt == CNT_W'(ADC_W - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adc_uart_formatter.sv
// Periodically snapshots the merged ADC bus and streams "Ckk=dddd " fields plus
// CR LF into the UART TX FIFO. FORMATTER_CHECKSUM_EN adds "*XX" before CR LF.
module adc_uart_formatter
    import adc_uart_formatter_pkg::*;
#(
    parameter int CHANNELS    = 13,
    parameter int ADC_W       = 12,
    parameter int FRAME_TICKS = 6_500_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*ADC_W-1:0] adc_in,
    input  logic                      tx_full,
    output logic [7:0]                sign,
    output logic                      tick,
    output logic                      busy
);

    localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
`ifdef FORMATTER_CHECKSUM_EN
    localparam int TAIL_LEN = 5;
`else
    localparam int TAIL_LEN = 2;
`endif

    state_t state_q, state_d;

    logic [CNT_W-1:0]          cnt;
    logic                      wrap, pending, clr_pend;
    logic [CHANNELS*ADC_W-1:0] snap;
    logic [CH_W-1:0]           ch;
    logic [7:0]                ch_num;
    logic [3:0]                bidx;
    logic                      conv_busy, start, done;
    logic [15:0]               bcd;
    logic [ADC_W-1:0]          cur_code;
    logic                      tick_prev, can_wr;
    logic [7:0]                sign_last, emit_byte, tail_byte, cur_byte;
`ifdef FORMATTER_CHECKSUM_EN
    logic [7:0]                xsum;
`endif

    assign wrap     = (cnt == CNT_W'(FRAME_TICKS - 1));
    assign cur_code = `ADC_SLICE(snap, int'(ch), ADC_W);
    assign ch_num   = 8'(ch);
    assign can_wr   = !tx_full && !tick_prev;
    assign busy     = (state_q != S_IDLE);

    bin2bcd_seq #(.ADC_W(ADC_W)) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (cur_code),
        .bcd   (bcd),
        .done  (done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        clr_pend = 1'b0;
        tick     = 1'b0;
        case (state_q)
            S_IDLE: if (pending) begin
                state_d  = S_LATCH;
                clr_pend = 1'b1;
            end
            S_LATCH: state_d = S_CONVERT;
            S_CONVERT: begin
                start = !conv_busy;
                if (done) state_d = S_EMIT;
            end
            S_EMIT: if (can_wr) begin
                tick = 1'b1;
                if (bidx == 4'(BYTES_PER_CH - 1))
                    state_d = (ch == LAST_CH) ? S_TAIL : S_CONVERT;
            end
            S_TAIL: if (can_wr) begin
                tick = 1'b1;
                if (bidx == 4'(TAIL_LEN - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        emit_byte = ASCII_SP;
        case (bidx)
            4'd0:    emit_byte = ASCII_C;
            4'd1:    emit_byte = ascii_digit(4'(ch_num / 8'd10));
            4'd2:    emit_byte = ascii_digit(4'(ch_num % 8'd10));
            4'd3:    emit_byte = ASCII_EQ;
            4'd4:    emit_byte = ascii_digit(bcd[15:12]);
            4'd5:    emit_byte = ascii_digit(bcd[11:8]);
            4'd6:    emit_byte = ascii_digit(bcd[7:4]);
            4'd7:    emit_byte = ascii_digit(bcd[3:0]);
            default: emit_byte = ASCII_SP;
        endcase
    end

    always_comb begin
        tail_byte = ASCII_LF;
`ifdef FORMATTER_CHECKSUM_EN
        case (bidx)
            4'd0:    tail_byte = ASCII_STAR;
            4'd1:    tail_byte = ascii_hex(xsum[7:4]);
            4'd2:    tail_byte = ascii_hex(xsum[3:0]);
            4'd3:    tail_byte = ASCII_CR;
            default: tail_byte = ASCII_LF;
        endcase
`else
        if (bidx == 4'd0) tail_byte = ASCII_CR;
`endif
    end

    // sign follows the byte being written and otherwise holds the last one
    assign cur_byte = (state_q == S_TAIL) ? tail_byte : emit_byte;
    assign sign     = tick ? cur_byte : sign_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            pending   <= 1'b0;
            snap      <= '0;
            ch        <= '0;
            bidx      <= '0;
            conv_busy <= 1'b0;
            tick_prev <= 1'b0;
            sign_last <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            // a wrap coinciding with the clear re-arms pending
            if (wrap)          pending <= 1'b1;
            else if (clr_pend) pending <= 1'b0;

            tick_prev <= tick;
            if (tick) sign_last <= cur_byte;

            if (start)     conv_busy <= 1'b1;
            else if (done) conv_busy <= 1'b0;

            if (state_q == S_LATCH) begin
                snap <= adc_in;
                ch   <= '0;
            end
            if (state_q == S_CONVERT && done) bidx <= '0;
            if (tick) begin
                if (state_q == S_EMIT && bidx == 4'(BYTES_PER_CH - 1)) begin
                    bidx <= '0;
                    if (ch != LAST_CH) ch <= ch + 1'b1;
                end else begin
                    bidx <= bidx + 1'b1;
                end
            end
        end
    end

`ifdef FORMATTER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         xsum <= '0;
        else if (state_q == S_LATCH)      xsum <= '0;
        else if (tick && state_q == S_EMIT) xsum <= xsum ^ cur_byte;
    end
`endif

endmodule
